axis_latency_pipe: RTL and testbench

//  Parametrised AXI-stream delay pipeline with full valid/ready handshake and bubble collapsing.

---
 rtl/axis_latency_pipe.sv | 175 +++++++++++++++++
 tb/tb_axis_latency_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_latency_pipe.sv
// rtl/axis_latency_pipe.sv - AXI-stream delay pipeline with bubble collapsing and marker latency measurement
// Stage DEPTH-1 drives the output; marker beats are tagged at input and timed to output handshake.
module axis_latency_pipe #(
  parameter int          WIDTH      = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] MARKER     = 32'habcdbeef,
  parameter int          STAMP_MODE = 1,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             stamp_en,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [6:0]       occupancy,
  output logic [CNT_W-1:0] latency,
  output logic             latency_stb,
  output logic [15:0]      marker_cnt,
  output logic [15:0]      marker_drop
);

  localparam int HALF = WIDTH / 2;

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_tag;
  logic [DEPTH-1:0] r_last;
  logic [WIDTH-1:0] r_data [DEPTH];

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tin;
  logic [CNT_W-1:0] r_lat;
  logic             r_trk;
  logic             r_stb;
  logic [15:0]      r_mcnt;
  logic [15:0]      r_drop;

  logic [DEPTH-1:0] w_adv;
  logic [6:0]       w_occ;
  logic [HALF-1:0]  w_mark;
  logic [HALF-1:0]  w_stamp;
  logic [WIDTH-1:0] w_in_data;
  logic             w_accept;
  logic             w_is_marker;
  logic             w_mark_acc;
  logic             w_hs;
  logic             w_release;
  logic             w_capture;
  logic             w_drop;

  if (HALF <= 32) begin : g_mark_narrow
    assign w_mark = MARKER[HALF-1:0];
  end else begin : g_mark_wide
    assign w_mark = {{(HALF-32){1'b0}}, MARKER};
  end

  if (CNT_W >= HALF) begin : g_stamp_trunc
    assign w_stamp = r_cnt[HALF-1:0];
  end else begin : g_stamp_ext
    assign w_stamp = {{(HALF-CNT_W){1'b0}}, r_cnt};
  end

  // A stage may advance when it or any stage downstream of it is empty, or the sink is ready.
  always_comb begin : adv_chain
    logic acc;
    w_adv = '0;
    acc   = o_tready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc      = acc | ~r_v[k];
      w_adv[k] = acc;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + 7'(r_v[k]);
    end
  end

  assign i_tready    = w_adv[0] & ~clear;
  assign w_accept    = i_tvalid & i_tready;
  assign w_is_marker = stamp_en & (STAMP_MODE != 0) & (i_tdata[WIDTH-1:HALF] == w_mark);
  assign w_in_data   = ((STAMP_MODE == 1) && w_is_marker) ? {i_tdata[WIDTH-1:HALF], w_stamp} : i_tdata;

  assign w_hs        = r_v[DEPTH-1] & o_tready;
  assign w_release   = w_hs & r_tag[DEPTH-1];
  assign w_mark_acc  = w_accept & w_is_marker;
  // Releasing and capturing on the same cycle hands tracking straight to the new marker.
  assign w_capture   = w_mark_acc & (~r_trk | w_release);
  assign w_drop      = w_mark_acc & r_trk & ~w_release;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v    <= '0;
      r_tag  <= '0;
      r_last <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else if (clear) begin
      r_v   <= '0;
      r_tag <= '0;
    end else begin
      if (w_adv[0]) begin
        r_v[0]    <= w_accept;
        r_tag[0]  <= w_capture;
        r_last[0] <= i_tlast;
        r_data[0] <= w_in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_adv[k]) begin
          r_v[k]    <= r_v[k-1];
          r_tag[k]  <= r_tag[k-1];
          r_last[k] <= r_last[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tin  <= '0;
      r_lat  <= '0;
      r_trk  <= 1'b0;
      r_stb  <= 1'b0;
      r_mcnt <= '0;
      r_drop <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (clear) begin
        r_trk  <= 1'b0;
        r_lat  <= '0;
        r_stb  <= 1'b0;
        r_mcnt <= '0;
        r_drop <= '0;
      end else begin
        r_stb <= w_release;
        if (w_release) begin
          r_lat <= r_cnt - r_tin;
          if (r_mcnt != 16'hFFFF) begin
            r_mcnt <= r_mcnt + 16'd1;
          end
        end
        if (w_capture) begin
          r_trk <= 1'b1;
          r_tin <= r_cnt;
        end else if (w_release) begin
          r_trk <= 1'b0;
        end
        if (w_drop && (r_drop != 16'hFFFF)) begin
          r_drop <= r_drop + 16'd1;
        end
      end
    end
  end

  assign o_tvalid    = r_v[DEPTH-1];
  assign o_tdata     = r_data[DEPTH-1];
  assign o_tlast     = r_last[DEPTH-1];
  assign occupancy   = w_occ;
  assign latency     = r_lat;
  assign latency_stb = r_stb;
  assign marker_cnt  = r_mcnt;
  assign marker_drop = r_drop;

endmodule

// File: tb/tb_axis_latency_pipe.sv
// tb/tb_axis_latency_pipe.sv - self-checking bench for axis_latency_pipe
// Queue-based reference: beats leave in order, each reaching the output at max(accept+DEPTH-1, previous departure).
module tb_axis_latency_pipe;
  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset, clear, stamp_en;
  logic [W-1:0]  i_tdata;
  logic          i_tlast, i_tvalid, i_tready;
  logic [W-1:0]  o_tdata;
  logic          o_tlast, o_tvalid, o_tready;
  logic [6:0]    occupancy;
  logic [31:0]   latency;
  logic          latency_stb;
  logic [15:0]   marker_cnt, marker_drop;

  int checks = 0;
  int errors = 0;
  int e = 0;

  logic [W-1:0] q_data [$];
  logic         q_last [$];
  logic         q_tag  [$];
  int           q_acc  [$];
  int           last_dep = 0;
  logic [31:0]  m_cnt = 0, m_tin = 0, m_lat = 0;
  logic         m_trk = 0, m_stb = 0, m_acc = 0;
  logic [15:0]  m_mcnt = 0, m_drop = 0;

  bit t1_arm = 0;
  int t1_first = -1, n_out = 0, n_last = 0;

  axis_latency_pipe #(
    .WIDTH(W), .DEPTH(D), .MARKER(32'h0000abcd), .STAMP_MODE(1), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .stamp_en(stamp_en),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .occupancy(occupancy), .latency(latency), .latency_stb(latency_stb),
    .marker_cnt(marker_cnt), .marker_drop(marker_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit head_valid();
    int arr;
    if (q_data.size() == 0) return 1'b0;
    arr = q_acc[0] + D - 1;
    if (last_dep > arr) arr = last_dep;
    return arr <= e;
  endfunction

  always @(posedge clk) begin : model
    bit hv, hs, rel, acc, ism;
    logic [W-1:0] d;
    if (reset) begin
      q_data.delete(); q_last.delete(); q_tag.delete(); q_acc.delete();
      m_cnt = 0; m_trk = 0; m_lat = 0; m_stb = 0; m_mcnt = 0; m_drop = 0;
      m_acc = 0; last_dep = 0;
    end else begin
      if (clear) begin
        q_data.delete(); q_last.delete(); q_tag.delete(); q_acc.delete();
        m_trk = 0; m_lat = 0; m_stb = 0; m_mcnt = 0; m_drop = 0; m_acc = 0;
      end else begin
        hv  = head_valid();
        hs  = hv && o_tready;
        rel = hs && q_tag[0];
        acc = i_tvalid && (q_data.size() < D || o_tready);
        ism = acc && stamp_en && (i_tdata[31:16] == 16'habcd);
        d   = ism ? {i_tdata[31:16], m_cnt[15:0]} : i_tdata;
        m_stb = rel;
        m_acc = acc;
        if (rel) begin
          m_lat = m_cnt - m_tin;
          if (m_mcnt != 16'hffff) m_mcnt++;
          m_trk = 0;
        end
        if (ism && m_trk) begin
          if (m_drop != 16'hffff) m_drop++;
        end
        if (hs) begin
          void'(q_data.pop_front()); void'(q_last.pop_front());
          void'(q_tag.pop_front());  void'(q_acc.pop_front());
          last_dep = e + 1;
        end
        if (acc) begin
          q_data.push_back(d); q_last.push_back(i_tlast);
          q_tag.push_back(ism && !m_trk); q_acc.push_back(e + 1);
        end
        if (ism && !m_trk) begin
          m_trk = 1;
          m_tin = m_cnt;
        end
      end
      m_cnt = m_cnt + 1;
    end
    e++;
  end

  always @(negedge clk) begin : cmp
    bit hv;
    if (!reset) begin
      hv = head_valid();
      chk("o_tvalid", o_tvalid, hv);
      chk("i_tready", i_tready, !clear && (q_data.size() < D || o_tready));
      chk("occupancy", occupancy, q_data.size());
      if (hv) begin
        chk("o_tdata", o_tdata, q_data[0]);
        chk("o_tlast", o_tlast, q_last[0]);
      end
      chk("latency", latency, m_lat);
      chk("latency_stb", latency_stb, m_stb);
      chk("marker_cnt", marker_cnt, m_mcnt);
      chk("marker_drop", marker_drop, m_drop);
    end
    if (t1_arm) begin
      if (o_tvalid && t1_first < 0) t1_first = e;
      if (o_tvalid && o_tready) begin
        n_out++;
        if (o_tlast) n_last++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 300; k++) begin
      if (q_data.size() == 0) break;
      step();
    end
    chk(nm, q_data.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_stb(input string nm);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (latency_stb) break;
    end
    chk(nm, latency_stb, 1);
  endtask

  initial begin : wdog
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int v;
    int acc_n;
    reset = 1'b1; clear = 1'b0; stamp_en = 1'b0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_o_tvalid", o_tvalid, 0);
    chk("rst_i_tready", i_tready, 1);
    chk("rst_marker_cnt", marker_cnt, 0);
    chk("rst_latency", latency, 0);
    step();

    // continuous stream, first beat appears after DEPTH cycles
    o_tready = 1'b1;
    v = e;
    t1_arm = 1; t1_first = -1; n_out = 0; n_last = 0;
    for (int i = 1; i <= 64; i++) begin
      i_tvalid = 1'b1; i_tdata = 32'(i); i_tlast = (i % 8 == 0);
      step();
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
    drain("t1_drain");
    t1_arm = 0;
    chk("t1_first_latency", t1_first - v, 4);
    chk("t1_beats_out", n_out, 64);
    chk("t1_tlast_out", n_last, 8);

    // full pipe held by back-pressure
    o_tready = 1'b0;
    v = 32'h100;
    for (int i = 0; i < 10; i++) begin
      i_tvalid = 1'b1; i_tdata = 32'(v);
      step();
      if (m_acc) v++;
    end
    @(negedge clk);
    chk("t2_occupancy", occupancy, 4);
    chk("t2_i_tready", i_tready, 0);
    chk("t2_o_tdata_held", o_tdata, 32'h100);
    chk("t2_accepted", v, 32'h104);
    step();
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    drain("t2_drain");

    // single marker stamped at counter 0x64
    pulse_reset();
    stamp_en = 1'b1; o_tready = 1'b1;
    for (int k = 0; k < 300 && m_cnt != 32'd100; k++) step();
    i_tvalid = 1'b1; i_tdata = 32'habcd0000; i_tlast = 1'b1;
    step();
    i_tvalid = 1'b0; i_tlast = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_tvalid) break;
    end
    chk("t4_o_tdata", o_tdata, 32'habcd0064);
    wait_stb("t4_stb");
    chk("t4_latency", latency, 4);
    chk("t4_marker_cnt", marker_cnt, 1);
    @(negedge clk);
    chk("t4_stb_one_pulse", latency_stb, 0);
    step();

    // back-to-back markers, first stalled 6 cycles at the output
    pulse_reset();
    stamp_en = 1'b1; o_tready = 1'b1;
    i_tvalid = 1'b1; i_tdata = 32'habcd1111;
    step();
    i_tdata = 32'habcd2222; o_tready = 1'b0;
    step();
    i_tvalid = 1'b0;
    repeat (8) step();
    o_tready = 1'b1;
    wait_stb("t5_stb");
    chk("t5_latency", latency, 10);
    chk("t5_marker_drop", marker_drop, 1);
    chk("t5_marker_cnt", marker_cnt, 1);
    step();
    drain("t5_drain");

    // clear with three valid stages
    stamp_en = 1'b0; o_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_tvalid = 1'b1; i_tdata = 32'h600 + 32'(i); i_tlast = 1'b0;
      step();
    end
    i_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_occ_before_clear", occupancy, 3);
    step();
    clear = 1'b1; i_tvalid = 1'b1; i_tdata = 32'h6ff;
    @(negedge clk);
    chk("t6_clear_i_tready", i_tready, 0);
    step();
    clear = 1'b0; i_tvalid = 1'b0;
    @(negedge clk);
    chk("t6_clear_occupancy", occupancy, 0);
    chk("t6_clear_o_tvalid", o_tvalid, 0);
    chk("t6_clear_marker_cnt", marker_cnt, 0);
    chk("t6_clear_marker_drop", marker_drop, 0);
    chk("t6_clear_latency", latency, 0);
    step();
    o_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_tvalid = 1'b1; i_tdata = 32'h700 + 32'(i); i_tlast = (i == 4);
      step();
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
    drain("t6_clear_drain");

    // asynchronous reset with three valid stages
    o_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_tvalid = 1'b1; i_tdata = 32'h800 + 32'(i);
      step();
    end
    i_tvalid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_rst_occupancy", occupancy, 0);
    chk("t6_rst_o_tvalid", o_tvalid, 0);
    step(); step();
    reset = 1'b0;
    o_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_tvalid = 1'b1; i_tdata = 32'h900 + 32'(i); i_tlast = (i == 4);
      step();
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
    drain("t6_rst_drain");

    // randomized traffic with markers and occasional clear
    acc_n = 0;
    for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
      i_tvalid = 1'($urandom_range(0, 1));
      o_tready = 1'($urandom_range(0, 1));
      stamp_en = ($urandom_range(0, 3) != 0);
      i_tdata  = {(($urandom_range(0, 7) == 0) ? 16'habcd : 16'($urandom)), 16'($urandom)};
      i_tlast  = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 999) == 0);
      step();
      if (m_acc) acc_n++;
    end
    clear = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    chk("t3_beats_accepted", acc_n >= 10000, 1);
    drain("t3_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
